edge_detect_multi: RTL and testbench

- Parametrised multi-channel edge detector; successor to the single-channel rising-edge pulse generator.
- Per channel: synchroniser, optional debounce, rise/fall/both mode select, one-cycle tick, sticky pending flag with clear.
- Aggregate irq for a processor interrupt line.
- Sits between raw board inputs (buttons, switches, async strobes) and the processor/counter logic.

---
 rtl/edge_detect_multi.sv | 197 +++++++++++++++++++
 tb/tb_edge_detect_multi.sv | 433 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/edge_detect_multi.sv
// edge_detect_multi: multi-channel edge detector for raw board inputs.
// Each channel has a synchroniser, an optional debounce filter, a
// rise/fall/both mode select, a one-cycle registered tick and a sticky
// pending flag. irq is the OR of all pending flags.
// Optional feature macro: EDGE_CNT_EN adds per-channel saturating event
// counters with a registered read port (cnt_sel / cnt_clr / cnt_val).
module edge_detect_multi #(
    parameter int unsigned N_CH        = 4,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned DEB_CYCLES  = 4
`ifdef EDGE_CNT_EN
    ,
    parameter int unsigned CNT_W       = 8
`endif
) (
    input  logic                                       clk,
    input  logic                                       reset,
    input  logic [N_CH-1:0]                            level,
    input  logic [2*N_CH-1:0]                          mode,
    input  logic [N_CH-1:0]                            clr,
    output logic [N_CH-1:0]                            tick,
    output logic [N_CH-1:0]                            pend,
    output logic                                       irq
`ifdef EDGE_CNT_EN
    ,
    input  logic [((N_CH > 1) ? $clog2(N_CH) : 1)-1:0] cnt_sel,
    input  logic                                       cnt_clr,
    output logic [CNT_W-1:0]                           cnt_val
`endif
);

    // ------------------------------------------------------------------
    // Input synchroniser
    // ------------------------------------------------------------------
    logic [N_CH-1:0] sync_q [SYNC_STAGES];
    logic [N_CH-1:0] sync_out;

    // Shift the raw asynchronous inputs through the synchroniser chain
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int s = 0; s < SYNC_STAGES; s++) begin
                sync_q[s] <= '0;
            end
        end else begin
            sync_q[0] <= level;
            for (int s = 1; s < SYNC_STAGES; s++) begin
                sync_q[s] <= sync_q[s-1];
            end
        end
    end

    assign sync_out = sync_q[SYNC_STAGES-1];

    // ------------------------------------------------------------------
    // Debounce: a new level is accepted only after DEB_CYCLES consecutive
    // samples disagree with the current stable level.
    // ------------------------------------------------------------------
    logic [N_CH-1:0] stable;

    if (DEB_CYCLES > 0) begin : g_deb
        localparam int unsigned   DebW    = $clog2(DEB_CYCLES + 1);
        localparam logic [DebW-1:0] DebLast = DebW'(DEB_CYCLES - 1);

        logic [DebW-1:0] deb_q [N_CH];
        logic [DebW-1:0] deb_d [N_CH];
        logic [N_CH-1:0] stable_q;
        logic [N_CH-1:0] stable_d;

        // Count disagreeing samples; any agreeing sample restarts the count
        always_comb begin
            stable_d = stable_q;
            for (int i = 0; i < N_CH; i++) begin
                deb_d[i] = '0;
                if (sync_out[i] != stable_q[i]) begin
                    if (deb_q[i] == DebLast) begin
                        stable_d[i] = sync_out[i];
                    end else begin
                        deb_d[i] = deb_q[i] + 1'b1;
                    end
                end
            end
        end

        // Debounce state registers
        always_ff @(posedge clk) begin
            if (reset) begin
                stable_q <= '0;
                for (int i = 0; i < N_CH; i++) begin
                    deb_q[i] <= '0;
                end
            end else begin
                stable_q <= stable_d;
                for (int i = 0; i < N_CH; i++) begin
                    deb_q[i] <= deb_d[i];
                end
            end
        end

        assign stable = stable_q;
    end else begin : g_nodeb
        assign stable = sync_out;
    end

    // ------------------------------------------------------------------
    // Edge detection, tick and pending flags
    // ------------------------------------------------------------------
    logic [N_CH-1:0] prev_q;
    logic [N_CH-1:0] tick_q, tick_d;
    logic [N_CH-1:0] pend_q, pend_d;
    logic [N_CH-1:0] rise, fall;
    logic [N_CH-1:0] mode_rise, mode_fall;

    // Split the packed 2-bit-per-channel mode field into rise/fall enables
    always_comb begin
        mode_rise = '0;
        mode_fall = '0;
        for (int i = 0; i < N_CH; i++) begin
            mode_rise[i] = mode[2*i];
            mode_fall[i] = mode[2*i+1];
        end
    end

    // prev tracks stable regardless of mode, so re-enabling is spurious-free
    assign rise   = stable & ~prev_q;
    assign fall   = ~stable & prev_q;
    assign tick_d = (rise & mode_rise) | (fall & mode_fall);
    // A new event beats a coinciding clear so nothing is lost
    assign pend_d = tick_d | (pend_q & ~clr);

    // Detection and flag registers
    always_ff @(posedge clk) begin
        if (reset) begin
            prev_q <= '0;
            tick_q <= '0;
            pend_q <= '0;
        end else begin
            prev_q <= stable;
            tick_q <= tick_d;
            pend_q <= pend_d;
        end
    end

    assign tick = tick_q;
    assign pend = pend_q;
    assign irq  = |pend_q;

`ifdef EDGE_CNT_EN
    // ------------------------------------------------------------------
    // Per-channel saturating event counters
    // ------------------------------------------------------------------
    localparam int unsigned SelW = (N_CH > 1) ? $clog2(N_CH) : 1;

    logic [CNT_W-1:0] cnt_q [N_CH];
    logic [CNT_W-1:0] cnt_d [N_CH];
    logic [CNT_W-1:0] cnt_val_q, cnt_val_d;

    // Count ticks, saturating at all-ones; a global clear beats a tick
    always_comb begin
        for (int i = 0; i < N_CH; i++) begin
            cnt_d[i] = cnt_q[i];
            if (cnt_clr) begin
                cnt_d[i] = '0;
            end else if (tick_d[i] && (cnt_q[i] != '1)) begin
                cnt_d[i] = cnt_q[i] + 1'b1;
            end
        end
    end

    // Read mux; selects beyond the last channel read as zero
    always_comb begin
        cnt_val_d = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (cnt_sel == SelW'(i)) begin
                cnt_val_d = cnt_q[i];
            end
        end
    end

    // Counter and read-port registers
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_val_q <= '0;
            for (int i = 0; i < N_CH; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            cnt_val_q <= cnt_val_d;
            for (int i = 0; i < N_CH; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign cnt_val = cnt_val_q;
`endif

endmodule

// File: tb/tb_edge_detect_multi.sv
// Directed testbench for edge_detect_multi. Main DUT: 4 channels, 2 sync
// stages, 4-cycle debounce. Second DUT: 5 channels, debounce bypassed.
module tb_edge_detect_multi;

    logic       clk;
    logic       reset;
    logic [3:0] level;
    logic [7:0] mode;
    logic [3:0] clr;
    logic [3:0] tick;
    logic [3:0] pend;
    logic       irq;

    logic [4:0] level0;
    logic [9:0] mode0;
    logic [4:0] clr0;
    logic [4:0] tick0;
    logic [4:0] pend0;
    logic       irq0;

    assign level0 = {1'b0, level};
    assign mode0  = {2'b01, mode};
    assign clr0   = {1'b0, clr};

`ifdef EDGE_CNT_EN
    logic [1:0] cnt_sel;
    logic       cnt_clr;
    logic [1:0] cnt_val;
    logic [2:0] cnt_sel0;
    logic [1:0] cnt_val0;
`endif

    int tests = 0;
    int fails = 0;

    edge_detect_multi #(
        .N_CH       (4),
        .SYNC_STAGES(2),
        .DEB_CYCLES (4)
`ifdef EDGE_CNT_EN
        ,
        .CNT_W      (2)
`endif
    ) dut (
        .clk  (clk),
        .reset(reset),
        .level(level),
        .mode (mode),
        .clr  (clr),
        .tick (tick),
        .pend (pend),
        .irq  (irq)
`ifdef EDGE_CNT_EN
        ,
        .cnt_sel(cnt_sel),
        .cnt_clr(cnt_clr),
        .cnt_val(cnt_val)
`endif
    );

    edge_detect_multi #(
        .N_CH       (5),
        .SYNC_STAGES(2),
        .DEB_CYCLES (0)
`ifdef EDGE_CNT_EN
        ,
        .CNT_W      (2)
`endif
    ) dut0 (
        .clk  (clk),
        .reset(reset),
        .level(level0),
        .mode (mode0),
        .clr  (clr0),
        .tick (tick0),
        .pend (pend0),
        .irq  (irq0)
`ifdef EDGE_CNT_EN
        ,
        .cnt_sel(cnt_sel0),
        .cnt_clr(cnt_clr),
        .cnt_val(cnt_val0)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) step();
        tests++;
        if (tick !== 4'b0000) begin
            fails++; $display("FAIL reset_tick got %b expected %b", tick, 4'b0000);
        end
        tests++;
        if (pend !== 4'b0000) begin
            fails++; $display("FAIL reset_pend got %b expected %b", pend, 4'b0000);
        end
        tests++;
        if (irq !== 1'b0) begin
            fails++; $display("FAIL reset_irq got %b expected 0", irq);
        end
`ifdef EDGE_CNT_EN
        tests++;
        if (cnt_val !== 2'd0) begin
            fails++; $display("FAIL reset_cnt_val got %0d expected 0", cnt_val);
        end
`endif
        reset = 1'b0;
        repeat (8) step();
        tests++;
        if (tick !== 4'b0000 || pend !== 4'b0000) begin
            fails++;
            $display("FAIL idle_after_reset got tick=%b pend=%b expected 0000/0000", tick, pend);
        end
    endtask

    // level[0] 0->1 under rise mode: tick on the 7th edge after the change
    task automatic test_rise();
        logic [3:0] exp;
        level[0] = 1'b1;
        for (int n = 1; n <= 10; n++) begin
            step();
            exp = (n == 7) ? 4'b0001 : 4'b0000;
            tests++;
            if (tick !== exp) begin
                fails++; $display("FAIL rise_tick n=%0d got %b expected %b", n, tick, exp);
            end
        end
        tests++;
        if (pend !== 4'b0001 || irq !== 1'b1) begin
            fails++;
            $display("FAIL rise_pend got pend=%b irq=%b expected 0001/1", pend, irq);
        end
    endtask

    // ch1 in both mode: rise then fall tick, pending held until cleared
    task automatic test_both();
        logic [3:0] exp;
        mode[3:2] = 2'b11;
        step();
        level[1] = 1'b1;
        for (int n = 1; n <= 35; n++) begin
            step();
            exp = (n == 7 || n == 27) ? 4'b0010 : 4'b0000;
            tests++;
            if (tick !== exp) begin
                fails++; $display("FAIL both_tick n=%0d got %b expected %b", n, tick, exp);
            end
            if (n == 20) level[1] = 1'b0;
        end
        tests++;
        if (pend !== 4'b0011 || irq !== 1'b1) begin
            fails++;
            $display("FAIL both_pend got pend=%b irq=%b expected 0011/1", pend, irq);
        end
        clr = 4'b0011;
        step();
        clr = 4'b0000;
        tests++;
        if (pend !== 4'b0000 || irq !== 1'b0) begin
            fails++;
            $display("FAIL clr_pend got pend=%b irq=%b expected 0000/0", pend, irq);
        end
    endtask

    // 3-cycle glitch on ch2: filtered with debounce, rise-only tick without
    task automatic test_glitch();
        logic [4:0] exp0;
        level[2] = 1'b1;
        for (int n = 1; n <= 15; n++) begin
            step();
            exp0 = (n == 3) ? 5'b00100 : 5'b00000;
            tests++;
            if (tick !== 4'b0000) begin
                fails++; $display("FAIL glitch_tick n=%0d got %b expected 0000", n, tick);
            end
            tests++;
            if (tick0 !== exp0) begin
                fails++; $display("FAIL glitch_nodeb_tick n=%0d got %b expected %b", n, tick0, exp0);
            end
            if (n == 3) level[2] = 1'b0;
        end
        tests++;
        if (pend[2] !== 1'b0) begin
            fails++; $display("FAIL glitch_pend got %b expected 0", pend[2]);
        end
        tests++;
        if (pend0[2] !== 1'b1 || irq0 !== 1'b1) begin
            fails++;
            $display("FAIL glitch_nodeb_pend got pend=%b irq=%b expected 1/1", pend0[2], irq0);
        end
    endtask

    // clr[3] on the same edge tick[3] is set: set wins
    task automatic test_clr_collision();
        logic [3:0] exp;
        level[3] = 1'b1;
        for (int n = 1; n <= 10; n++) begin
            step();
            exp = (n == 7) ? 4'b1000 : 4'b0000;
            tests++;
            if (tick !== exp) begin
                fails++; $display("FAIL coll_tick n=%0d got %b expected %b", n, tick, exp);
            end
            if (n == 6) clr[3] = 1'b1;
            if (n == 7) clr[3] = 1'b0;
        end
        tests++;
        if (pend !== 4'b1000) begin
            fails++; $display("FAIL coll_pend got %b expected 1000", pend);
        end
        clr[3] = 1'b1;
        step();
        clr[3] = 1'b0;
        tests++;
        if (pend !== 4'b0000) begin
            fails++; $display("FAIL coll_clear got %b expected 0000", pend);
        end
    endtask

    // ch3 off while its level moves, then re-enabled: no spurious tick
    task automatic test_mode_off();
        mode[7:6] = 2'b00;
        step();
        for (int ph = 0; ph < 3; ph++) begin
            if (ph == 0) level[3] = 1'b0;
            if (ph == 1) level[3] = 1'b1;
            if (ph == 2) mode[7:6] = 2'b01;
            for (int n = 1; n <= 12; n++) begin
                step();
                tests++;
                if (tick !== 4'b0000) begin
                    fails++;
                    $display("FAIL mode_off_tick ph=%0d n=%0d got %b expected 0000", ph, n, tick);
                end
            end
        end
        tests++;
        if (pend !== 4'b0000) begin
            fails++; $display("FAIL mode_off_pend got %b expected 0000", pend);
        end
    endtask

    // ch0 in fall-only mode: 1->0 produces a tick
    task automatic test_fall_mode();
        logic [3:0] exp;
        mode[1:0] = 2'b10;
        step();
        level[0] = 1'b0;
        for (int n = 1; n <= 10; n++) begin
            step();
            exp = (n == 7) ? 4'b0001 : 4'b0000;
            tests++;
            if (tick !== exp) begin
                fails++; $display("FAIL fall_tick n=%0d got %b expected %b", n, tick, exp);
            end
        end
        tests++;
        if (pend !== 4'b0001) begin
            fails++; $display("FAIL fall_pend got %b expected 0001", pend);
        end
        clr = 4'b1111;
        step();
        clr = 4'b0000;
    endtask

    // All channels change together: all ticks in the same cycle
    task automatic test_back_to_back();
        logic [3:0] exp;
        mode = 8'hFF;
        step();
        level = ~level;
        for (int n = 1; n <= 10; n++) begin
            step();
            exp = (n == 7) ? 4'b1111 : 4'b0000;
            tests++;
            if (tick !== exp) begin
                fails++; $display("FAIL multi_tick n=%0d got %b expected %b", n, tick, exp);
            end
        end
        tests++;
        if (pend !== 4'b1111 || irq !== 1'b1) begin
            fails++;
            $display("FAIL multi_pend got pend=%b irq=%b expected 1111/1", pend, irq);
        end
        clr = 4'b1111;
        step();
        clr = 4'b0000;
    endtask

    // Level high through reset release: one rise per channel
    task automatic test_reset_release();
        logic [3:0] exp;
        level = 4'b1111;
        reset = 1'b1;
        repeat (3) step();
        tests++;
        if (tick !== 4'b0000 || pend !== 4'b0000 || irq !== 1'b0) begin
            fails++;
            $display("FAIL rr_in_reset got tick=%b pend=%b irq=%b expected 0000/0000/0",
                     tick, pend, irq);
        end
        reset = 1'b0;
        for (int n = 1; n <= 12; n++) begin
            step();
            exp = (n == 7) ? 4'b1111 : 4'b0000;
            tests++;
            if (tick !== exp) begin
                fails++; $display("FAIL rr_tick n=%0d got %b expected %b", n, tick, exp);
            end
        end
        clr = 4'b1111;
        step();
        clr = 4'b0000;
    endtask

    // Reset in the middle of a debounce: nothing reported
    task automatic test_reset_abort();
        level = 4'b0000;
        repeat (4) step();
        reset = 1'b1;
        repeat (2) step();
        reset = 1'b0;
        for (int n = 1; n <= 15; n++) begin
            step();
            tests++;
            if (tick !== 4'b0000) begin
                fails++; $display("FAIL abort_tick n=%0d got %b expected 0000", n, tick);
            end
        end
        tests++;
        if (pend !== 4'b0000 || irq !== 1'b0) begin
            fails++;
            $display("FAIL abort_pend got pend=%b irq=%b expected 0000/0", pend, irq);
        end
    endtask

`ifdef EDGE_CNT_EN
    task automatic test_counters();
        mode = 8'h55;
        cnt_sel = 2'd0;
        cnt_sel0 = 3'd0;
        for (int p = 0; p < 5; p++) begin
            level[0] = 1'b1;
            repeat (10) step();
            level[0] = 1'b0;
            repeat (10) step();
        end
        repeat (2) step();
        tests++;
        if (cnt_val !== 2'd3) begin
            fails++; $display("FAIL cnt_sat got %0d expected 3", cnt_val);
        end
        cnt_sel = 2'd1;
        cnt_sel0 = 3'd5;
        repeat (2) step();
        tests++;
        if (cnt_val !== 2'd0) begin
            fails++; $display("FAIL cnt_sel1 got %0d expected 0", cnt_val);
        end
        tests++;
        if (cnt_val0 !== 2'd0) begin
            fails++; $display("FAIL cnt_sel_oob got %0d expected 0", cnt_val0);
        end
        cnt_sel0 = 3'd0;
        repeat (2) step();
        tests++;
        if (cnt_val0 !== 2'd3) begin
            fails++; $display("FAIL cnt_nodeb_sat got %0d expected 3", cnt_val0);
        end
        cnt_sel = 2'd0;
        level[0] = 1'b1;
        for (int n = 1; n <= 10; n++) begin
            step();
            if (n == 6) cnt_clr = 1'b1;
            if (n == 7) cnt_clr = 1'b0;
        end
        tests++;
        if (cnt_val !== 2'd0) begin
            fails++; $display("FAIL cnt_clr_wins got %0d expected 0", cnt_val);
        end
        level[0] = 1'b0;
        repeat (10) step();
        level[0] = 1'b1;
        repeat (10) step();
        tests++;
        if (cnt_val !== 2'd1) begin
            fails++; $display("FAIL cnt_after_clr got %0d expected 1", cnt_val);
        end
    endtask
`endif

    initial begin
        reset = 1'b1;
        level = 4'b0000;
        mode  = 8'h55;
        clr   = 4'b0000;
`ifdef EDGE_CNT_EN
        cnt_sel  = 2'd0;
        cnt_sel0 = 3'd0;
        cnt_clr  = 1'b0;
`endif
        test_reset();
        test_rise();
        test_both();
        test_glitch();
        test_clr_collision();
        test_mode_off();
        test_fall_mode();
        test_back_to_back();
        test_reset_release();
        test_reset_abort();
`ifdef EDGE_CNT_EN
        test_counters();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
